// File: rtl/adc_capture_writer.sv
// rtl/adc_capture_writer.sv - ADC sample stream to RAM port-2 capture writer
// One-shot or ping-pong ring capture with decimation and half-buffer interrupts.
module adc_capture_writer #(
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 16,
   parameter int DECIM_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                stop,
   input  logic                continuous,
   input  logic [ADDR_W:0]     capture_len,
   input  logic [DECIM_W-1:0]  decim,
   input  logic                irq_ack,
   input  logic                sample_valid,
   input  logic [DATA_W-1:0]   sample_data,
   output logic                sample_ready,
   output logic [ADDR_W-1:0]   address2,
   output logic                chipselect2,
   output logic                write2,
   output logic [DATA_W-1:0]   writedata2,
   output logic [1:0]          byteenable2,
   output logic                clken2,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   wr_ptr,
   output logic                irq_pending,
   output logic                half_sel,
   output logic                overflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LOWER_LAST = ADDR_W'(DEPTH/2 - 1);
   localparam logic [ADDR_W-1:0] UPPER_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FULL_LEN   = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t               state, state_nx;
   logic                 cont_l;
   logic [ADDR_W:0]      len_l;
   logic [DECIM_W-1:0]   decim_l;
   logic [DECIM_W-1:0]   dec_cnt;
   logic [ADDR_W:0]      count;
   logic                 wr_q;

   logic                 accept, do_write, last_write, start_cap;
   logic                 lower_done, upper_done, half_done;
   logic [ADDR_W:0]      count_nx, len_eff;

   assign byteenable2  = 2'b11;
   assign clken2       = 1'b1;
   assign chipselect2  = wr_q;
   assign write2       = wr_q;
   assign busy         = (state == CAPTURE);
   assign sample_ready = (state == CAPTURE);

   always_comb begin
      accept     = (state == CAPTURE) && sample_valid;
      do_write   = accept && (dec_cnt == decim_l);
      count_nx   = count + 1'b1;
      len_eff    = (len_l == '0) ? FULL_LEN : len_l;
      last_write = do_write && !cont_l && (count_nx == len_eff);
      lower_done = do_write && (wr_ptr == LOWER_LAST);
      upper_done = do_write && (wr_ptr == UPPER_LAST);
      half_done  = lower_done || upper_done;
      start_cap  = start && (state != CAPTURE);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = CAPTURE;
         CAPTURE: begin
            if (stop)            state_nx = IDLE;
            else if (last_write) state_nx = DONE;
         end
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         cont_l      <= 1'b0;
         len_l       <= '0;
         decim_l     <= '0;
         dec_cnt     <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         wr_q        <= 1'b0;
         address2    <= '0;
         writedata2  <= '0;
         done        <= 1'b0;
         irq_pending <= 1'b0;
         half_sel    <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state <= state_nx;
         // The write is issued one cycle after acceptance, even if stop lands on the accept edge.
         wr_q  <= do_write;
         if (do_write) begin
            address2   <= wr_ptr;
            writedata2 <= sample_data;
         end

         if (start_cap) begin
            cont_l      <= continuous;
            len_l       <= capture_len;
            decim_l     <= decim;
            dec_cnt     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            done        <= 1'b0;
            irq_pending <= 1'b0;
            half_sel    <= 1'b0;
            overflow    <= 1'b0;
         end else begin
            if (accept) dec_cnt <= do_write ? '0 : dec_cnt + 1'b1;
            if (do_write) begin
               wr_ptr <= wr_ptr + 1'b1;
               count  <= count_nx;
            end
            if (last_write && !stop) done <= 1'b1;
            // A completion beats a coincident ack; an ack in the same cycle counts as servicing the old one.
            if (half_done) begin
               irq_pending <= 1'b1;
               half_sel    <= upper_done;
               if (irq_pending && !irq_ack) overflow <= 1'b1;
            end else if (irq_ack) begin
               irq_pending <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_capture_writer.sv
// tb/tb_adc_capture_writer.sv - directed self-checking bench for adc_capture_writer
// Uses a 16-word buffer so half and wrap boundaries are reached quickly.
module tb_adc_capture_writer;

   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 16;
   localparam int DECIM_W = 8;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                start, stop, continuous, irq_ack, sample_valid;
   logic [ADDR_W:0]     capture_len;
   logic [DECIM_W-1:0]  decim;
   logic [DATA_W-1:0]   sample_data;
   logic                sample_ready, chipselect2, write2, clken2;
   logic [ADDR_W-1:0]   address2, wr_ptr;
   logic [DATA_W-1:0]   writedata2;
   logic [1:0]          byteenable2;
   logic                busy, done, irq_pending, half_sel, overflow;

   int checks = 0;
   int errors = 0;

   adc_capture_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DECIM_W(DECIM_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .continuous(continuous), .capture_len(capture_len), .decim(decim),
      .irq_ack(irq_ack), .sample_valid(sample_valid), .sample_data(sample_data),
      .sample_ready(sample_ready), .address2(address2), .chipselect2(chipselect2),
      .write2(write2), .writedata2(writedata2), .byteenable2(byteenable2),
      .clken2(clken2), .busy(busy), .done(done), .wr_ptr(wr_ptr),
      .irq_pending(irq_pending), .half_sel(half_sel), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_write(input string tag, input logic en, input logic [31:0] addr, input logic [31:0] data);
      chk({tag, "_write2"}, 32'(write2), 32'(en));
      chk({tag, "_cs2"}, 32'(chipselect2), 32'(en));
      if (en) begin
         chk({tag, "_addr"}, 32'(address2), addr);
         chk({tag, "_data"}, 32'(writedata2), data);
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; irq_ack = 1'b0;
      sample_valid = 1'b0; capture_len = '0; decim = '0; sample_data = '0;

      // Reset state
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(sample_ready), 0);
      chk("rst_write", 32'(write2), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_wr_ptr", 32'(wr_ptr), 0);
      chk("rst_irq", 32'(irq_pending), 0);
      chk("rst_be", 32'(byteenable2), 3);
      chk("rst_clken", 32'(clken2), 1);
      reset_n = 1'b1;
      tick();

      // One-shot, 4 samples, no decimation
      start = 1'b1; capture_len = 5'd4; decim = 8'd0;
      tick();
      start = 1'b0;
      chk("os_busy", 32'(busy), 1);
      chk("os_ready", 32'(sample_ready), 1);
      chk("os_idle_write", 32'(write2), 0);
      sample_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample_data = 16'h1001 + 16'(i);
         tick();
         chk_write("os", 1'b1, 32'(i), 32'h1001 + 32'(i));
      end
      chk("os_done", 32'(done), 1);
      chk("os_busy_end", 32'(busy), 0);
      chk("os_ready_end", 32'(sample_ready), 0);
      chk("os_wr_ptr", 32'(wr_ptr), 4);
      tick();
      chk("os_no_extra_write", 32'(write2), 0);
      chk("os_wr_ptr_hold", 32'(wr_ptr), 4);
      sample_valid = 1'b0;

      // One-shot with decimation by 3
      start = 1'b1; capture_len = 5'd6; decim = 8'd2;
      tick();
      start = 1'b0;
      chk("dec_done_cleared", 32'(done), 0);
      sample_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sample_data = 16'h00A0 + 16'(i);
         tick();
         if (i == 2)      chk_write("dec", 1'b1, 0, 32'hA2);
         else if (i == 5) chk_write("dec", 1'b1, 1, 32'hA5);
         else             chk_write("dec", 1'b0, 0, 0);
      end
      sample_valid = 1'b0;
      tick();
      chk("dec_not_done", 32'(done), 0);
      chk("dec_busy", 32'(busy), 1);
      chk("dec_wr_ptr", 32'(wr_ptr), 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("dec_stopped", 32'(busy), 0);

      // Ring mode: lower half then upper half without ack
      start = 1'b1; continuous = 1'b1; decim = 8'd0;
      tick();
      start = 1'b0;
      sample_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sample_data = 16'h2000 + 16'(i);
         tick();
      end
      chk_write("ring_lo", 1'b1, 7, 32'h2007);
      chk("ring_lo_irq", 32'(irq_pending), 1);
      chk("ring_lo_half", 32'(half_sel), 0);
      chk("ring_lo_ovf", 32'(overflow), 0);
      chk("ring_lo_ptr", 32'(wr_ptr), 8);
      for (int i = 8; i < 16; i++) begin
         sample_data = 16'h2000 + 16'(i);
         tick();
      end
      chk_write("ring_hi", 1'b1, 15, 32'h200F);
      chk("ring_hi_ptr", 32'(wr_ptr), 0);
      chk("ring_hi_half", 32'(half_sel), 1);
      chk("ring_hi_ovf", 32'(overflow), 1);
      chk("ring_hi_irq", 32'(irq_pending), 1);
      chk("ring_no_done", 32'(done), 0);
      sample_valid = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;

      // Ring mode: ack coincides with the upper completion
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ack_ovf_cleared", 32'(overflow), 0);
      sample_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sample_data = 16'h3000 + 16'(i);
         irq_ack = (i == 15);
         tick();
      end
      irq_ack = 1'b0;
      chk("ack_coincide_irq", 32'(irq_pending), 1);
      chk("ack_coincide_ovf", 32'(overflow), 0);
      chk("ack_coincide_half", 32'(half_sel), 1);
      sample_valid = 1'b0; irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("ack_clears_irq", 32'(irq_pending), 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      // Stop on an accept cycle
      start = 1'b1; continuous = 1'b0; capture_len = 5'd4;
      tick();
      start = 1'b0;
      sample_valid = 1'b1; sample_data = 16'h5555; stop = 1'b1;
      tick();
      stop = 1'b0; sample_valid = 1'b0;
      chk("stop_busy", 32'(busy), 0);
      chk("stop_ready", 32'(sample_ready), 0);
      chk_write("stop", 1'b1, 0, 32'h5555);
      sample_valid = 1'b1;
      tick();
      chk("stop_no_write", 32'(write2), 0);
      chk("stop_done", 32'(done), 0);
      chk("stop_wr_ptr", 32'(wr_ptr), 1);
      sample_valid = 1'b0;

      // Start and stop together in CAPTURE
      start = 1'b1;
      tick();
      chk("ss_busy_first", 32'(busy), 1);
      stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("ss_idle", 32'(busy), 0);

      // One-shot with capture_len 0 covers the whole buffer
      start = 1'b1; capture_len = 5'd0;
      tick();
      start = 1'b0;
      sample_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         sample_data = 16'h4000 + 16'(i);
         tick();
      end
      chk("full_not_done", 32'(done), 0);
      chk("full_busy", 32'(busy), 1);
      sample_data = 16'h400F;
      tick();
      chk_write("full_last", 1'b1, 15, 32'h400F);
      chk("full_done", 32'(done), 1);
      chk("full_wrap", 32'(wr_ptr), 0);
      sample_valid = 1'b0;

      // Reset during ring capture with a write pending
      start = 1'b1; continuous = 1'b1;
      tick();
      start = 1'b0;
      sample_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sample_data = 16'h6000 + 16'(i);
         tick();
      end
      chk("prerst_write", 32'(write2), 1);
      chk("prerst_irq", 32'(irq_pending), 1);
      reset_n = 1'b0;
      tick();
      chk("mrst_write", 32'(write2), 0);
      chk("mrst_cs", 32'(chipselect2), 0);
      chk("mrst_ready", 32'(sample_ready), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_irq", 32'(irq_pending), 0);
      chk("mrst_ptr", 32'(wr_ptr), 0);
      chk("mrst_half", 32'(half_sel), 0);
      reset_n = 1'b1; sample_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
